// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: 2-bit counters with tag/target per entry,
// trained from execute, issuing a registered redirect on misprediction.
module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic            flush_valid,
    output logic [XLEN-1:0] flush_pc,
    output logic [31:0]     mispredict_cnt
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = XLEN - IDX_BITS - 2;

    logic             valid_q  [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];

    logic            flush_valid_q, flush_valid_d;
    logic [XLEN-1:0] flush_pc_q, flush_pc_d;
    logic [31:0]     mispredict_cnt_q, mispredict_cnt_d;

    logic [IDX_BITS-1:0] fetch_idx, upd_idx;
    logic [TAG_W-1:0]    fetch_tag, upd_tag;
    logic                fetch_hit, upd_hit, mispredict;

    logic            wr_en;
    logic [1:0]      wr_ctr;
    logic [XLEN-1:0] wr_target;

    // Byte-offset bits of the PCs carry no information for index or tag.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0]};

    assign fetch_idx = fetch_pc[IDX_BITS+1:2];
    assign fetch_tag = fetch_pc[XLEN-1:IDX_BITS+2];
    assign upd_idx   = upd_pc[IDX_BITS+1:2];
    assign upd_tag   = upd_pc[XLEN-1:IDX_BITS+2];

    assign fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign pred_taken  = fetch_hit && ctr_q[fetch_idx][1];
    assign pred_target = fetch_hit ? target_q[fetch_idx] : fetch_pc + XLEN'(4);

    assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign mispredict = (upd_pred_taken != upd_taken) ||
                        (upd_taken && upd_pred_taken && (upd_pred_target != upd_target));

    always_comb begin
        wr_en     = upd_valid && (upd_hit || upd_taken);
        wr_ctr    = ctr_q[upd_idx];
        wr_target = target_q[upd_idx];
        if (!upd_hit) begin
            wr_ctr    = 2'b10;
            wr_target = upd_target;
        end else if (upd_taken) begin
            wr_ctr    = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'b01;
            wr_target = upd_target;
        end else begin
            wr_ctr    = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'b01;
        end
    end

    always_comb begin
        flush_valid_d    = upd_valid && mispredict;
        flush_pc_d       = flush_pc_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (upd_valid) begin
            flush_pc_d = upd_taken ? upd_target : upd_pc + XLEN'(4);
            if (mispredict && (mispredict_cnt_q != 32'hFFFF_FFFF))
                mispredict_cnt_d = mispredict_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                ctr_q[i]    <= 2'b01;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
            flush_valid_q    <= 1'b0;
            flush_pc_q       <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (wr_en) begin
                valid_q[upd_idx]  <= 1'b1;
                ctr_q[upd_idx]    <= wr_ctr;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= wr_target;
            end
            flush_valid_q    <= flush_valid_d;
            flush_pc_q       <= flush_pc_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign flush_valid    = flush_valid_q;
    assign flush_pc       = flush_pc_q;
    assign mispredict_cnt = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic [31:0] mispredict_cnt;

    int checks   = 0;
    int failures = 0;

    branch_predictor #(.IDX_BITS(6), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .flush_valid(flush_valid), .flush_pc(flush_pc),
        .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                           input logic ptk, input logic [31:0] ptg);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tg;
        upd_pred_taken  = ptk;
        upd_pred_target = ptg;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                       input logic ptk, input logic [31:0] ptg);
        set_upd(pc, tk, tg, ptk, ptg);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic exp_tk, input logic [31:0] exp_tg);
        fetch_pc = pc;
        #1;
        chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
        chk({tag, "_target"}, pred_target, exp_tg);
    endtask

    task automatic flush_chk(input string tag, input logic exp_v,
                             input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
        chk({tag, "_fv"}, {31'd0, flush_valid}, {31'd0, exp_v});
        if (exp_v) chk({tag, "_fpc"}, flush_pc, exp_pc);
        chk({tag, "_cnt"}, mispredict_cnt, exp_cnt);
    endtask

    initial begin
        rst = 1'b1;
        fetch_pc = 32'h100;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_pred_taken = 1'b0; upd_pred_target = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fv", {31'd0, flush_valid}, 32'd0);
        chk("rst_fpc", flush_pc, 32'd0);
        chk("rst_cnt", mispredict_cnt, 32'd0);
        look("cold", 32'h100, 1'b0, 32'h104);
        rst = 1'b0;
        @(posedge clk); #1;

        upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        flush_chk("alloc", 1'b1, 32'h80, 32'd1);
        look("alloc", 32'h100, 1'b1, 32'h80);
        @(posedge clk); #1;
        flush_chk("idle", 1'b0, 32'h0, 32'd1);

        for (int i = 0; i < 3; i++) begin
            upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
            flush_chk("sat_tk", 1'b0, 32'h0, 32'd1);
        end
        upd(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        flush_chk("nt1", 1'b1, 32'h104, 32'd2);
        look("nt1", 32'h100, 1'b1, 32'h80);
        upd(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        flush_chk("nt2", 1'b1, 32'h104, 32'd3);
        look("nt2", 32'h100, 1'b0, 32'h80);

        upd(32'h200, 1'b1, 32'h240, 1'b0, 32'h0);
        flush_chk("alias", 1'b1, 32'h240, 32'd4);
        look("alias_old", 32'h100, 1'b0, 32'h104);
        look("alias_new", 32'h200, 1'b1, 32'h240);

        upd(32'h200, 1'b1, 32'h90, 1'b1, 32'h80);
        flush_chk("tgt", 1'b1, 32'h90, 32'd5);
        look("tgt", 32'h200, 1'b1, 32'h90);
        upd(32'h200, 1'b1, 32'h90, 1'b1, 32'h90);
        flush_chk("correct", 1'b0, 32'h0, 32'd5);

        upd(32'h400, 1'b0, 32'h0, 1'b0, 32'h0);
        flush_chk("miss_nt", 1'b0, 32'h0, 32'd5);
        look("miss_nt", 32'h200, 1'b1, 32'h90);
        upd(32'h104, 1'b0, 32'h0, 1'b1, 32'h50);
        flush_chk("miss_nt_mp", 1'b1, 32'h108, 32'd6);

        fetch_pc = 32'h300;
        set_upd(32'h300, 1'b1, 32'h500, 1'b0, 32'h0);
        #1;
        chk("same_cyc_before", {31'd0, pred_taken}, 32'd0);
        @(posedge clk); #1;
        upd_valid = 1'b0;
        chk("same_cyc_after", {31'd0, pred_taken}, 32'd1);
        chk("same_cyc_tgt", pred_target, 32'h500);
        flush_chk("same_cyc", 1'b1, 32'h500, 32'd7);

        upd(32'h600, 1'b1, 32'h700, 1'b0, 32'h0);
        flush_chk("pre_rst", 1'b1, 32'h700, 32'd8);
        set_upd(32'h600, 1'b0, 32'h0, 1'b1, 32'h700);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_fv", {31'd0, flush_valid}, 32'd0);
        chk("rst_mid_fpc", flush_pc, 32'd0);
        chk("rst_mid_cnt", mispredict_cnt, 32'd0);
        @(posedge clk); #1;
        upd_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        flush_chk("post_rst", 1'b0, 32'h0, 32'd0);
        look("post_rst_600", 32'h600, 1'b0, 32'h604);
        look("post_rst_200", 32'h200, 1'b0, 32'h204);

        look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
        upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h10);
        flush_chk("upd_wrap", 1'b1, 32'h0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Front-end consumer of the execute-stage branch decision (branch_out from the branch comparator).
- Predicts direction and target for conditional branches at fetch, using a direct-mapped table: 2-bit saturating counter, valid bit, tag and target per entry.
- Trains the table on resolved outcomes from execute.
- Issues a registered flush/redirect to fetch on misprediction.

Parameters:
IDX_BITS, 6, log2 of table entries (64 entries); index = pc[IDX_BITS+1:2]
XLEN, 32, address width; tag = pc[XLEN-1:IDX_BITS+2]

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
fetch_pc  input  XLEN  PC being fetched this cycle
pred_taken  output  1  combinational: valid && tag hit && ctr[1]
pred_target  output  XLEN  combinational: stored target on hit, else fetch_pc+4
upd_valid  input  1  execute has resolved a conditional branch this cycle
upd_pc  input  XLEN  PC of the resolved branch
upd_taken  input  1  resolved direction (branch_out)
upd_target  input  XLEN  resolved taken-target (PC+imm)
upd_pred_taken  input  1  prediction carried down the pipe with this branch
upd_pred_target  input  XLEN  predicted target carried down the pipe
flush_valid  output  1  registered one-cycle redirect pulse
flush_pc  output  XLEN  registered redirect address
mispredict_cnt  output  32  saturating count of mispredictions

Behaviour:
- Reset (async, immediate):
  - All valid bits 0; all counters 2'b01 (weakly not-taken).
  - flush_valid=0, flush_pc=0, mispredict_cnt=0.
  - pred_taken=0; pred_target=fetch_pc+4.
- Lookup: purely combinational from registered table state, zero latency, no bypass.
  - A same-cycle update to the same index is not visible to lookup until the next cycle.
- Mispredict condition, evaluated only when upd_valid=1:
  - (upd_pred_taken != upd_taken), or
  - (upd_taken && upd_pred_taken && upd_pred_target != upd_target).
- Redirect, on the edge after the update cycle:
  - flush_valid <= upd_valid && mispredict.
  - flush_pc <= upd_taken ? upd_target : upd_pc+4.
  - flush_valid is a single-cycle pulse; it deasserts the next cycle unless another mispredict occurs.
  - Back-to-back mispredicts yield back-to-back pulses, each carrying its own flush_pc.
- Table update when upd_valid=1, at index i=upd_pc[IDX_BITS+1:2]:
  - Hit (valid && tag match), taken: ctr = min(ctr+1, 3); target <= upd_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate. valid=1, tag=upd_pc tag, target=upd_target, ctr=2'b10 (weakly taken). Unconditionally replaces any previous entry.
  - Miss, not taken: no table change.
- mispredict_cnt increments by 1 per mispredicting update and saturates at 32'hFFFF_FFFF.
- Arithmetic:
  - fetch_pc+4 and upd_pc+4 are XLEN-bit and wrap modulo 2^XLEN; 32'hFFFF_FFFC+4 = 0.
  - Bits [1:0] of all PCs are ignored for index and tag.
- Reset asserted mid-operation:
  - Pending update and flush are discarded.
  - Table and counters return to reset values in the same instant.
  - No flush pulse is produced after reset deassertion.
- upd_valid=0: table, flush_pc and mispredict_cnt hold; flush_valid goes 0.

Test Plan:
- Cold lookup: after reset, fetch_pc=0x100 -> pred_taken=0, pred_target=0x104; mispredict_cnt=0.
- Allocate and redirect: upd_pc=0x100, upd_taken=1, upd_target=0x80, upd_pred_taken=0 -> next cycle flush_valid=1, flush_pc=0x80, mispredict_cnt=1. Then fetch_pc=0x100 -> pred_taken=1, pred_target=0x80.
- Saturation/hysteresis on entry 0x100:
  - Three more taken updates -> ctr=3.
  - One not-taken update -> pred_taken still 1.
  - Second not-taken -> pred_taken=0.
  - Flush_pc on the not-taken mispredict = 0x104.
- Alias replacement: after 0x100 allocated, taken update at 0x200 (same index, IDX_BITS=6) -> fetch_pc=0x100 misses (pred_taken=0); fetch_pc=0x200 hits with the new target.
- Target mispredict: both predicted and resolved taken, upd_pred_target=0x80, upd_target=0x90 -> flush_pc=0x90, stored target becomes 0x90.
- Same-cycle conflict and reset:
  - Lookup of 0x300 while allocating 0x300 -> pred_taken=0 that cycle, 1 the next.
  - Assert rst in the cycle after a mispredicting update -> flush_valid stays 0, table cleared.
- Wrap: fetch_pc=0xFFFF_FFFC on a miss -> pred_target=0x0000_0000.
